// File: rtl/ps2_device_tx.sv
// ps2_device_tx: device-side PS/2 transmitter (mouse/keyboard emulation).
// Generates PS2CLK itself and sends 11-bit frames (start 0, 8 data bits LSB
// first, odd parity, stop 1) through open-drain pull-low enables. A host
// inhibit while the clock is released aborts the frame; the byte is kept and
// resent from the start bit once the bus has been idle again.
// Optional build macro PS2DEV_RETRY_LIMIT_EN: drop the byte and pulse FAIL on
// the third consecutive abort of the same byte.
module ps2_device_tx #(
    parameter int HALF_CYC = 2000,
    parameter int IDLE_CYC = 2500,
    parameter int RISE_CYC = 100
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] TX_DATA,
    input  logic       TX_VALID,
    output logic       TX_READY,
    output logic       TX_DONE,
    output logic       ABORT,
    output logic       FAIL,
    output logic       HOST_RTS,
    output logic       BUSY,
    input  logic       PS2CLK_IN,
    input  logic       PS2DATA_IN,
    output logic       PS2CLK_OE,
    output logic       PS2DATA_OE
);

    localparam int CNT_MAX = (HALF_CYC > IDLE_CYC) ? HALF_CYC : IDLE_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_BUS,
        ST_BIT_HIGH,
        ST_BIT_LOW,
        ST_DONE,
        ST_ABORT
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] idle_cnt;
    logic [CNT_W-1:0] cyc_cnt;
    logic [3:0]       bit_idx;
    logic [10:0]      frame_sr;
    logic             accept;
    logic             clk_p0, clk_p1;
    logic             dat_p0, dat_p1;
`ifdef PS2DEV_RETRY_LIMIT_EN
    logic [1:0]       abort_cnt;
`endif

    // Odd parity: the parity bit makes the total count of ones odd.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

    assign accept = (state == ST_IDLE) && TX_VALID && TX_READY;

    // Two-flop synchronisers for the pad inputs; the bus counts as busy until seen high.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            clk_p0 <= 1'b0;
            clk_p1 <= 1'b0;
            dat_p0 <= 1'b0;
            dat_p1 <= 1'b0;
        end else begin
            clk_p0 <= PS2CLK_IN;
            clk_p1 <= clk_p0;
            dat_p0 <= PS2DATA_IN;
            dat_p1 <= dat_p0;
        end
    end

    // Host request-to-send: host holds data low while the clock is high.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) HOST_RTS <= 1'b0;
        else      HOST_RTS <= clk_p1 & ~dat_p1;
    end

    // Frame image latched on accept; kept intact so an abort can resend it.
    always_ff @(posedge CLK) begin
        if (accept) frame_sr <= {1'b1, odd_parity(TX_DATA), TX_DATA, 1'b0};
    end

    // Transmit FSM: handshake, bus-idle wait, bit clocking, abort and completion.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= ST_IDLE;
            idle_cnt   <= '0;
            cyc_cnt    <= '0;
            bit_idx    <= '0;
            PS2CLK_OE  <= 1'b0;
            PS2DATA_OE <= 1'b0;
            TX_READY   <= 1'b0;
            TX_DONE    <= 1'b0;
            ABORT      <= 1'b0;
            BUSY       <= 1'b0;
`ifdef PS2DEV_RETRY_LIMIT_EN
            FAIL       <= 1'b0;
            abort_cnt  <= '0;
`endif
        end else begin
            TX_DONE <= 1'b0;
            ABORT   <= 1'b0;
`ifdef PS2DEV_RETRY_LIMIT_EN
            FAIL    <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        TX_READY <= 1'b0;
                        BUSY     <= 1'b1;
                        idle_cnt <= '0;
                        state    <= ST_WAIT_BUS;
`ifdef PS2DEV_RETRY_LIMIT_EN
                        abort_cnt <= '0;
`endif
                    end else begin
                        TX_READY <= 1'b1;
                    end
                end
                ST_WAIT_BUS: begin
                    if (clk_p1 && dat_p1) begin
                        if (idle_cnt == CNT_W'(IDLE_CYC - 1)) begin
                            state      <= ST_BIT_HIGH;
                            bit_idx    <= '0;
                            cyc_cnt    <= '0;
                            PS2CLK_OE  <= 1'b0;
                            PS2DATA_OE <= ~frame_sr[0];
                        end else begin
                            idle_cnt <= idle_cnt + 1'b1;
                        end
                    end else begin
                        idle_cnt <= '0;
                    end
                end
                ST_BIT_HIGH: begin
                    // Clock low while we release it means the host is inhibiting;
                    // during the stop bit the frame already counts as delivered.
                    if ((cyc_cnt >= CNT_W'(RISE_CYC)) && !clk_p1 && (bit_idx <= 4'd9)) begin
                        PS2CLK_OE  <= 1'b0;
                        PS2DATA_OE <= 1'b0;
                        ABORT      <= 1'b1;
                        idle_cnt   <= '0;
                        state      <= ST_ABORT;
`ifdef PS2DEV_RETRY_LIMIT_EN
                        if (abort_cnt == 2'd2) begin
                            FAIL      <= 1'b1;
                            BUSY      <= 1'b0;
                            abort_cnt <= '0;
                        end else begin
                            abort_cnt <= abort_cnt + 1'b1;
                        end
`endif
                    end else if (cyc_cnt == CNT_W'(HALF_CYC - 1)) begin
                        cyc_cnt   <= '0;
                        PS2CLK_OE <= 1'b1;
                        state     <= ST_BIT_LOW;
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
                ST_BIT_LOW: begin
                    if (cyc_cnt == CNT_W'(HALF_CYC - 1)) begin
                        cyc_cnt   <= '0;
                        PS2CLK_OE <= 1'b0;
                        if (bit_idx == 4'd10) begin
                            PS2DATA_OE <= 1'b0;
                            TX_DONE    <= 1'b1;
                            BUSY       <= 1'b0;
                            state      <= ST_DONE;
`ifdef PS2DEV_RETRY_LIMIT_EN
                            abort_cnt  <= '0;
`endif
                        end else begin
                            bit_idx    <= bit_idx + 4'd1;
                            PS2DATA_OE <= ~frame_sr[bit_idx + 4'd1];
                            state      <= ST_BIT_HIGH;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    TX_READY <= 1'b1;
                    state    <= ST_IDLE;
                end
                ST_ABORT: begin
                    // BUSY is already clear here only when the byte was dropped.
                    if (BUSY) begin
                        state <= ST_WAIT_BUS;
                    end else begin
                        TX_READY <= 1'b1;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifndef PS2DEV_RETRY_LIMIT_EN
    assign FAIL = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_device_tx.sv
// Testbench for ps2_device_tx with a bench-side PS/2 host model on the bus.
// Stimulus pushes hand-computed {parity,data} words into a queue; a monitor
// collects bits on each device-driven PS2CLK falling edge and checks frames.
module tb_ps2_device_tx;

    localparam int HALF      = 20;
    localparam int IDLE      = 50;
    localparam int RISE      = 5;
    localparam int READY_LAT = IDLE + 22 * HALF + 1;

    logic       CLK;
    logic       RST;
    logic [7:0] TX_DATA;
    logic       TX_VALID;
    logic       TX_READY, TX_DONE, ABORT, FAIL, HOST_RTS, BUSY;
    logic       PS2CLK_OE, PS2DATA_OE;
    logic       host_clk_low, host_dat_low;
    logic       ps2clk_pad, ps2dat_pad;

    assign ps2clk_pad = ~(PS2CLK_OE | host_clk_low);
    assign ps2dat_pad = ~(PS2DATA_OE | host_dat_low);

    ps2_device_tx #(.HALF_CYC(HALF), .IDLE_CYC(IDLE), .RISE_CYC(RISE)) dut (
        .CLK(CLK), .RST(RST), .TX_DATA(TX_DATA), .TX_VALID(TX_VALID),
        .TX_READY(TX_READY), .TX_DONE(TX_DONE), .ABORT(ABORT), .FAIL(FAIL),
        .HOST_RTS(HOST_RTS), .BUSY(BUSY), .PS2CLK_IN(ps2clk_pad),
        .PS2DATA_IN(ps2dat_pad), .PS2CLK_OE(PS2CLK_OE), .PS2DATA_OE(PS2DATA_OE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int abort_seen = 0;
    int fail_cnt = 0;
    int fall_total = 0;
    logic [8:0]  exp_q[$];
    logic [10:0] mon_bits;
    int          mon_n = 0;
    int          mon_last = 0;
    logic        mon_prev = 1'b1;
    logic        mon_spacing_bad = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!TX_READY && n < 3000) begin
            tick(1);
            n++;
        end
        if (!TX_READY) begin
            checks++;
            errors++;
            $display("FAIL %s: TX_READY still 0 after %0d cycles, expected 1", name, n);
        end
    endtask

    task automatic wait_clk_oe(input logic level, input string name);
        int n = 0;
        while (PS2CLK_OE !== level && n < 3000) begin
            tick(1);
            n++;
        end
        if (PS2CLK_OE !== level) begin
            checks++;
            errors++;
            $display("FAIL %s: PS2CLK_OE stuck at %0b, expected %0b", name, PS2CLK_OE, level);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        wait_ready("send_ready");
        TX_DATA  = b;
        TX_VALID = 1'b1;
        tick(1);
        TX_VALID = 1'b0;
    endtask

    // Host model / monitor: samples the bus away from the active edge
    initial begin
        logic [8:0] exp;
        forever begin
            @(negedge CLK);
            cyc++;
            if (TX_DONE) done_cnt++;
            if (ABORT) abort_seen++;
            if (FAIL) fail_cnt++;
            if (!RST || ABORT) begin
                mon_n = 0;
            end else if (mon_prev && !ps2clk_pad && PS2CLK_OE) begin
                fall_total++;
                if (mon_n == 0) mon_spacing_bad = 1'b0;
                else if (cyc - mon_last != 2 * HALF) mon_spacing_bad = 1'b1;
                mon_last = cyc;
                mon_bits[mon_n] = ps2dat_pad;
                mon_n++;
                if (mon_n == 11) begin
                    mon_n = 0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame: got frame %0h, expected none", mon_bits);
                    end else begin
                        exp = exp_q.pop_front();
                        check("start_bit", {31'd0, mon_bits[0]}, 32'd0);
                        check("stop_bit", {31'd0, mon_bits[10]}, 32'd1);
                        check("parity_data", {23'd0, mon_bits[9:1]}, {23'd0, exp});
                        check("edge_spacing", {31'd0, mon_spacing_bad}, 32'd0);
                    end
                end
            end
            mon_prev = ps2clk_pad;
        end
    end

    // Directed stimulus
    initial begin
        int d0, f0, a0, fl0, n;
        logic saw_clk;
        RST = 1'b0; TX_VALID = 1'b0; TX_DATA = 8'h00;
        host_clk_low = 1'b0; host_dat_low = 1'b0;
        tick(3);
        check("reset_outputs",
              {24'd0, PS2CLK_OE, PS2DATA_OE, TX_READY, TX_DONE, ABORT, FAIL, BUSY, HOST_RTS}, 32'd0);
        RST = 1'b1;
        tick(2);
        check("ready_after_reset", {31'd0, TX_READY}, 32'd1);

        // 0xA5 on an idle bus: bits 0,1,0,1,0,0,1,0,1,(par)1,(stop)1
        d0 = done_cnt; f0 = fall_total;
        exp_q.push_back(9'h1A5);
        send_byte(8'hA5);
        check("busy_after_accept", {30'd0, TX_READY, BUSY}, 32'd1);
        n = 0;
        while (!TX_READY && n < 3000) begin
            tick(1);
            n++;
        end
        check("ready_latency", n, READY_LAT);
        check("done_pulses_a5", done_cnt - d0, 1);
        check("falling_edges_a5", fall_total - f0, 11);

        // Parity: 0x01 -> parity 0, 0x00 -> parity 1
        exp_q.push_back(9'h001);
        send_byte(8'h01);
        wait_ready("done_01");
        exp_q.push_back(9'h100);
        send_byte(8'h00);
        wait_ready("done_00");

        // Host inhibit during bit 5 high phase, then full resend
        d0 = done_cnt; a0 = abort_seen;
        exp_q.push_back(9'h1A5);
        send_byte(8'hA5);
        tick(IDLE + 2 * HALF * 5 + HALF / 2 - 1);
        check("bit5_data_driven", {31'd0, PS2DATA_OE}, 32'd1);
        host_clk_low = 1'b1;
        tick(3);
        check("inhibit_abort_pulse", {31'd0, ABORT}, 32'd1);
        check("inhibit_lines_released", {30'd0, PS2CLK_OE, PS2DATA_OE}, 32'd0);
        tick(60);
        host_clk_low = 1'b0;
        wait_ready("done_after_inhibit");
        check("abort_pulses", abort_seen - a0, 1);
        check("done_after_resend", done_cnt - d0, 1);

        // Host RTS: data low with clock high holds off the frame
        host_dat_low = 1'b1;
        tick(4);
        check("host_rts_level", {31'd0, HOST_RTS}, 32'd1);
        exp_q.push_back(9'h001);
        send_byte(8'h01);
        saw_clk = 1'b0;
        repeat (200) begin
            tick(1);
            if (PS2CLK_OE) saw_clk = 1'b1;
        end
        check("rts_no_clock", {31'd0, saw_clk}, 32'd0);
        check("rts_busy", {31'd0, BUSY}, 32'd1);
        host_dat_low = 1'b0;
        n = 0;
        while (!PS2DATA_OE && n < 3000) begin
            tick(1);
            n++;
        end
        check("rts_start_delay", n, IDLE + 2);
        wait_ready("done_after_rts");

        // Reset in the middle of bit 3
        d0 = done_cnt;
        send_byte(8'h00);
        tick(IDLE + 2 * HALF * 3 + 4);
        check("bit3_data_driven", {31'd0, PS2DATA_OE}, 32'd1);
        #2 RST = 1'b0;
        #1;
        check("async_reset_release", {29'd0, PS2CLK_OE, PS2DATA_OE, BUSY}, 32'd0);
        tick(3);
        RST = 1'b1;
        tick(2);
        check("ready_after_midreset", {31'd0, TX_READY}, 32'd1);
        f0 = fall_total;
        tick(2 * READY_LAT);
        check("no_residual_edges", fall_total - f0, 0);
        check("no_residual_done", done_cnt - d0, 0);

        // Three consecutive inhibits of the same byte
        fl0 = fail_cnt; d0 = done_cnt;
        send_byte(8'h5A);
        for (int k = 0; k < 3; k++) begin
            wait_clk_oe(1'b1, "attempt_start");
            wait_clk_oe(1'b0, "attempt_bit1");
            tick(8);
            host_clk_low = 1'b1;
            tick(3);
            check("retry_abort_pulse", {31'd0, ABORT}, 32'd1);
`ifdef PS2DEV_RETRY_LIMIT_EN
            check("fail_with_abort", {31'd0, FAIL}, (k == 2) ? 32'd1 : 32'd0);
`else
            check("fail_tied_low", {31'd0, FAIL}, 32'd0);
`endif
            tick(30);
            host_clk_low = 1'b0;
        end
`ifdef PS2DEV_RETRY_LIMIT_EN
        tick(2);
        check("dropped_ready", {30'd0, TX_READY, BUSY}, 32'd2);
        check("fail_pulses", fail_cnt - fl0, 1);
`else
        check("still_busy", {31'd0, BUSY}, 32'd1);
        exp_q.push_back(9'h15A);
        wait_clk_oe(1'b1, "fourth_attempt");
        wait_ready("done_fourth");
        check("fourth_done", done_cnt - d0, 1);
        check("no_fail_pulses", fail_cnt - fl0, 0);
`endif
        tick(5);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_device_tx.md
Name: ps2_device_tx

Overview:
- Device-side PS/2 transmitter: the other end of our PS/2 host link, for emulating a mouse or keyboard toward a host.
- Generates PS2CLK itself and sends 11-bit frames: start 0, 8 data bits LSB first, odd parity, stop 1.
- Honours host inhibit and host request-to-send.
- Drives the bus through open-drain enables into the existing 1-bit tristate buffers; a byte source feeds it via valid/ready.

Parameters:
- HALF_CYC, 2000: CLK cycles per PS2CLK half-period (50 MHz -> 12.5 kHz).
- IDLE_CYC, 2500: consecutive cycles both lines must be high before a frame may start (50 us).
- RISE_CYC, 100: cycles after releasing PS2CLK before the inhibit check is armed.

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous, active-low reset
- TX_DATA  in  8  byte to send
- TX_VALID  in  1  byte available
- TX_READY  out  1  block accepts a byte this cycle
- TX_DONE  out  1  one-cycle pulse after a frame completes
- ABORT  out  1  one-cycle pulse when the host inhibits mid-frame
- FAIL  out  1  one-cycle pulse when a byte is dropped (optional feature only; otherwise tied 0)
- HOST_RTS  out  1  level: host holds data low while clock is high
- BUSY  out  1  a byte is held (pending or in flight)
- PS2CLK_IN  in  1  bus clock as read from the pad
- PS2DATA_IN  in  1  bus data as read from the pad
- PS2CLK_OE  out  1  1 = pull PS2CLK low, 0 = release
- PS2DATA_OE  out  1  1 = pull PS2DATA low, 0 = release

Behaviour:
- Reset (RST=0, asynchronous):
  - State is IDLE and the held byte is discarded.
  - Output values: PS2CLK_OE=0, PS2DATA_OE=0, TX_READY=0, TX_DONE=0, ABORT=0, FAIL=0, BUSY=0, HOST_RTS=0.
  - Both lines are released immediately, including in the middle of a frame.
- Synchronisers: PS2CLK_IN and PS2DATA_IN each pass through 2 flops; all decisions use the synchronised values.
- HOST_RTS = synced clock high AND synced data low. It is registered (1-cycle latency).
- Handshake:
  - TX_READY=1 only in IDLE.
  - A byte is accepted when TX_VALID=1 and TX_READY=1: the byte is latched, odd parity is computed, and the 11-bit shift register is loaded.
  - TX_READY falls the next cycle and BUSY rises.
- WAIT_BUS:
  - An idle counter counts cycles with both synced lines high; it clears whenever either line is low.
  - When the counter reaches IDLE_CYC, go to BIT_HIGH with bit index 0.
  - A HOST_RTS condition keeps the counter cleared, so the block waits indefinitely; this block does not receive commands.
- BIT_HIGH:
  - On entry: PS2CLK_OE=0 and PS2DATA_OE = NOT current bit.
  - Lasts HALF_CYC cycles.
  - From cycle RISE_CYC onward, a synced clock of 0 with bit index <= 9 means host inhibit -> ABORT state.
  - At the end of the half-period -> BIT_LOW.
- BIT_LOW:
  - PS2CLK_OE=1 (host samples on this falling edge); lasts HALF_CYC cycles.
  - Then: if bit index = 10 -> DONE, else increment the index -> BIT_HIGH.
- DONE:
  - Release both lines and pulse TX_DONE.
  - BUSY falls and the state returns to IDLE (TX_READY=1 on the following cycle).
- ABORT:
  - Release both lines in the same cycle and pulse ABORT.
  - The byte is retained and the state goes to WAIT_BUS (full retransmit from the start bit).
- Frame timing:
  - Period is 2*HALF_CYC; a frame is 22*HALF_CYC cycles after WAIT_BUS exits.
  - Data is stable for HALF_CYC before every falling edge.
- An inhibit during the 11th clock's high phase (bit index 10, the stop bit) is ignored; the frame is treated as delivered.
- Idle outputs are never driven high; only pull-low or release.

Optional Feature:
- Macro: PS2DEV_RETRY_LIMIT_EN.
- Defined:
  - A 2-bit abort counter increments on each ABORT and clears on TX_DONE or on a new accept.
  - On the 3rd consecutive abort of the same byte: drop the byte, pulse FAIL in the same cycle as ABORT, clear BUSY, return to IDLE.
- Undefined:
  - Unlimited retries; FAIL is tied 0 and no counter is present.

Test Plan:
- Send 0xA5 with the bus idle.
  - Expect exactly 11 PS2CLK falling edges, 4000 cycles apart.
  - Data sampled at each falling edge: 0,1,0,1,0,0,1,0,1,1(parity),1(stop).
  - TX_DONE pulses once; TX_READY returns after 22*HALF_CYC + IDLE_CYC + sync latency.
- Parity: send 0x01 -> parity bit 0; send 0x00 -> parity bit 1. Each byte is checked by a bench host model.
- Inhibit: the host model holds PS2CLK low for 100 us during bit 5's high phase.
  - ABORT pulses; both OE signals are 0 within 3 cycles.
  - After release plus 2500 idle cycles, the full 0xA5 frame is resent and TX_DONE pulses once.
- Host RTS: data held low with clock high before the accept.
  - HOST_RTS=1, no PS2CLK_OE activity, BUSY=1.
  - After release, the frame starts 2500 cycles later.
- Reset mid-frame: assert RST at bit 3.
  - Both OE signals are 0 asynchronously (before the next CLK edge) and BUSY=0.
  - After deassert, TX_READY=1 and no residual frame is sent.
- With PS2DEV_RETRY_LIMIT_EN: inhibit three consecutive attempts.
  - FAIL pulses with the 3rd ABORT, the byte is dropped, and TX_READY=1.
  - Without the macro, a 4th attempt starts.
